// File: rtl/memcpy_engine_pkg.sv
// memcpy_pkg: shared types and helpers for the memcpy_engine block.
//   state_e  - copy engine FSM states
//   rc_width - bit width that holds base+count sums without overflow
package memcpy_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COPY  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

  // One bit wider than the larger of address and count so that
  // base + num never wraps when compared against DEPTH.
  function automatic int rc_width(input int addr_w, input int len_w);
    return ((addr_w > len_w) ? addr_w : len_w) + 1;
  endfunction

endpackage

// File: rtl/memcpy_engine_if.sv
// memcpy_engine_if: host-side bundle of the memcpy_engine.
//   host_we/host_addr/host_wdata/host_rdata - word access to the RAM while idle
//   start/dest/src/num                      - copy request, sampled with start
//   busy/done/error                         - copy status
// master: host/driver side, slave: engine side.
interface memcpy_engine_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
);

  logic                  host_we;
  logic [ADDR_WIDTH-1:0] host_addr;
  logic [DATA_WIDTH-1:0] host_wdata;
  logic [DATA_WIDTH-1:0] host_rdata;
  logic                  start;
  logic [ADDR_WIDTH-1:0] dest;
  logic [ADDR_WIDTH-1:0] src;
  logic [LEN_WIDTH-1:0]  num;
  logic                  busy;
  logic                  done;
  logic                  error;

  modport master (
    output host_we, host_addr, host_wdata, start, dest, src, num,
    input  host_rdata, busy, done, error
  );

  modport slave (
    input  host_we, host_addr, host_wdata, start, dest, src, num,
    output host_rdata, busy, done, error
  );

endinterface

// File: rtl/memcpy_engine_ram_sdp.sv
// ram_sdp: simple dual-port RAM, one write port and one registered read port.
//   clk, rst_n       - clock, async active-low reset (read register only)
//   we/waddr/wdata   - synchronous write
//   raddr/rdata      - read, rdata valid one cycle after raddr
// A read and a write to the same word on the same edge returns the old word.
module ram_sdp #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/memcpy_engine.sv
// memcpy_engine: internal dual-port RAM plus a memmove-style block copier.
//   clk, rst_n - clock, async active-low reset
//   bus        - memcpy_engine_if slave: host RAM access, copy request/status
// The host owns the RAM ports while busy=0; the copier owns them while busy=1.
// Copy pipeline: read word at edge Ek, write it to its destination at E(k+1).
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | host access, waiting for start
// ST_COPY  | request latched; range check, then one source read per cycle
// ST_DRAIN | last read done, final write pending
// ST_FIN   | done (and error if rejected) pulse, back to idle
module memcpy_engine
  import memcpy_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 1 << ADDR_WIDTH,
  parameter int LEN_WIDTH  = 8
) (
  input  logic clk,
  input  logic rst_n,
  memcpy_engine_if.slave bus
);

  localparam int RW = rc_width(ADDR_WIDTH, LEN_WIDTH);
  localparam logic [RW-1:0] DEPTH_W = RW'(DEPTH);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] dest_q, dest_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d;
  logic [LEN_WIDTH-1:0]  num_q, num_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic                  wr_vld_q, wr_vld_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  rd_host_q, rd_host_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;

  logic [RW-1:0]         src_ext, dest_ext, num_ext, src_end, dest_end;
  logic                  range_err, desc;
  logic [LEN_WIDTH-1:0]  rd_off;
  logic [ADDR_WIDTH-1:0] rd_addr;

  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_waddr, ram_raddr;
  logic [DATA_WIDTH-1:0] ram_wdata, ram_rdata;

  assign src_ext   = RW'(src_q);
  assign dest_ext  = RW'(dest_q);
  assign num_ext   = RW'(num_q);
  assign src_end   = src_ext + num_ext;
  assign dest_end  = dest_ext + num_ext;
  assign range_err = (src_end > DEPTH_W) || (dest_end > DEPTH_W);
  // Destination inside the source window above src: copy top-down so
  // no source word is overwritten before it has been read.
  assign desc      = (dest_ext > src_ext) && (dest_ext < src_end);

  // rem_q counts reads still to issue; offset of the current read.
  assign rd_off  = desc ? (rem_q - LEN_WIDTH'(1)) : (num_q - rem_q);
  assign rd_addr = src_q + ADDR_WIDTH'(rd_off);

  always_comb begin
    state_d   = state_q;
    dest_d    = dest_q;
    src_d     = src_q;
    num_d     = num_q;
    rem_d     = rem_q;
    wr_vld_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          dest_d  = bus.dest;
          src_d   = bus.src;
          num_d   = bus.num;
          rem_d   = bus.num;
          busy_d  = 1'b1;
          state_d = ST_COPY;
        end
      end
      ST_COPY: begin
        if (range_err || (num_q == '0)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          error_d = range_err;
          state_d = ST_FIN;
        end else begin
          wr_vld_d  = 1'b1;
          wr_addr_d = dest_q + ADDR_WIDTH'(rd_off);
          rem_d     = rem_q - LEN_WIDTH'(1);
          if (rem_q == LEN_WIDTH'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_FIN;
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // host_rdata follows the RAM read register only when the previous read
  // was a host read; otherwise it holds the last host-visible value.
  assign rd_host_d = ~busy_q;
  assign hold_d    = bus.host_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      dest_q    <= '0;
      src_q     <= '0;
      num_q     <= '0;
      rem_q     <= '0;
      wr_vld_q  <= 1'b0;
      wr_addr_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      rd_host_q <= 1'b1;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      dest_q    <= dest_d;
      src_q     <= src_d;
      num_q     <= num_d;
      rem_q     <= rem_d;
      wr_vld_q  <= wr_vld_d;
      wr_addr_q <= wr_addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      rd_host_q <= rd_host_d;
      hold_q    <= hold_d;
    end
  end

  assign ram_we    = busy_q ? wr_vld_q  : bus.host_we;
  assign ram_waddr = busy_q ? wr_addr_q : bus.host_addr;
  assign ram_wdata = busy_q ? ram_rdata : bus.host_wdata;
  assign ram_raddr = busy_q ? rd_addr   : bus.host_addr;

  ram_sdp #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (DEPTH)
  ) u_ram (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );

  assign bus.host_rdata = rd_host_q ? ram_rdata : hold_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;

endmodule

// File: tb/tb_memcpy_engine.sv
// Self-checking bench for memcpy_engine: directed and random copies checked
// against a memmove reference model of the RAM contents.
module tb_memcpy_engine;

  localparam int DW    = 8;
  localparam int AW    = 8;
  localparam int LW    = 8;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  memcpy_engine_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

  memcpy_engine #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .LEN_WIDTH(LW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] model [DEPTH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic host_wr(input int a, input logic [DW-1:0] d);
    bus.host_we    = 1'b1;
    bus.host_addr  = a[AW-1:0];
    bus.host_wdata = d;
    @(negedge clk);
    bus.host_we    = 1'b0;
    model[a] = d;
  endtask

  task automatic scan(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      bus.host_addr = i[AW-1:0];
      @(negedge clk);
      chk($sformatf("%s_rd[%0h]", tag, i), 32'(bus.host_rdata), 32'(model[i]));
    end
  endtask

  // Issues one copy and checks busy/hold/done/error timing; updates the model
  // with memmove semantics. poke: interfere mid-copy. cowr: host write to src
  // in the same cycle as start.
  task automatic copy(input int d, input int s, input int n, input bit poke,
                      input bit cowr, input logic [DW-1:0] cowr_data);
    bit            exp_err;
    int            exp_lat;
    int            cyc;
    logic [DW-1:0] hold_exp;
    logic [DW-1:0] tmp [$];
    exp_err = (s + n > DEPTH) || (d + n > DEPTH);
    exp_lat = (exp_err || n == 0) ? 1 : n + 1;
    if (cowr) begin
      bus.host_we    = 1'b1;
      bus.host_addr  = s[AW-1:0];
      bus.host_wdata = cowr_data;
      model[s] = cowr_data;
    end else begin
      bus.host_addr = d[AW-1:0];
    end
    hold_exp  = model[d];
    bus.start = 1'b1;
    bus.dest  = d[AW-1:0];
    bus.src   = s[AW-1:0];
    bus.num   = n[LW-1:0];
    @(negedge clk);
    bus.start   = 1'b0;
    bus.host_we = 1'b0;
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 600) begin
      chk("busy_during", 32'(bus.busy), 32'd1);
      if (!cowr) chk("rdata_hold", 32'(bus.host_rdata), 32'(hold_exp));
      if (poke && cyc == 2) begin
        bus.host_we    = 1'b1;
        bus.host_addr  = d[AW-1:0];
        bus.host_wdata = ~model[s];
        bus.start      = 1'b1;
        bus.dest       = s[AW-1:0];
        bus.src        = d[AW-1:0];
        bus.num        = 8'd1;
      end else begin
        bus.host_we = 1'b0;
        bus.start   = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    chk("done_latency", 32'(cyc), 32'(exp_lat));
    chk("busy_at_done", 32'(bus.busy), 32'd0);
    chk("error_at_done", 32'(bus.error), 32'(exp_err));
    // start coincident with done must be ignored
    bus.start = 1'b1;
    bus.dest  = 8'h00;
    bus.src   = 8'h01;
    bus.num   = 8'd1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("done_pulse_end", 32'(bus.done), 32'd0);
    chk("error_pulse_end", 32'(bus.error), 32'd0);
    chk("start_at_done_ignored", 32'(bus.busy), 32'd0);
    if (!exp_err) begin
      for (int i = 0; i < n; i++) tmp.push_back(model[s + i]);
      for (int i = 0; i < n; i++) model[d + i] = tmp[i];
    end
  endtask

  initial begin
    bus.host_we    = 1'b0;
    bus.host_addr  = '0;
    bus.host_wdata = '0;
    bus.start      = 1'b0;
    bus.dest       = '0;
    bus.src        = '0;
    bus.num        = '0;
    #2;
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_error", 32'(bus.error), 32'd0);
    chk("reset_rdata", 32'(bus.host_rdata), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < DEPTH; i++) host_wr(i, i[DW-1:0] ^ 8'hA5);
    scan("load");

    copy(8'h80, 8'h10, 16, 1'b0, 1'b0, 8'h00);
    scan("fwd");

    for (int i = 0; i < 8; i++) host_wr(8'h20 + i, i[DW-1:0]);
    copy(8'h24, 8'h20, 8, 1'b0, 1'b0, 8'h00);
    scan("ovl_desc");
    copy(8'h20, 8'h24, 8, 1'b0, 1'b0, 8'h00);
    scan("ovl_asc");

    copy(8'h30, 8'h40, 0, 1'b0, 1'b0, 8'h00);
    copy(8'h00, 8'hF8, 9, 1'b0, 1'b0, 8'h00);
    copy(8'hF9, 8'h00, 8, 1'b0, 1'b0, 8'h00);
    copy(8'h40, 8'h40, 4, 1'b0, 1'b0, 8'h00);
    scan("reject");
    copy(8'h00, 8'hF8, 8, 1'b0, 1'b0, 8'h00);
    scan("edge_ok");

    copy(8'h60, 8'h50, 20, 1'b1, 1'b0, 8'h00);
    scan("busy_guard");

    copy(8'h90, 8'h50, 4, 1'b0, 1'b1, 8'h3C);
    scan("we_with_start");

    for (int r = 0; r < 8; r++) begin
      int s, d, n;
      s = int'($urandom_range(0, 255));
      n = int'($urandom_range(1, 40));
      if ($urandom_range(0, 1) == 1) d = (s + int'($urandom_range(0, 16)) - 8) & 255;
      else                           d = int'($urandom_range(0, 255));
      for (int k = 0; k < 16; k++) host_wr(int'($urandom_range(0, 255)), DW'($urandom));
      copy(d, s, n, 1'b0, 1'b0, 8'h00);
      scan($sformatf("rand%0d", r));
    end

    // async reset in the middle of a copy
    bus.start = 1'b1;
    bus.dest  = 8'h10;
    bus.src   = 8'h00;
    bus.num   = 8'd32;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_error", 32'(bus.error), 32'd0);
    chk("midrst_rdata", 32'(bus.host_rdata), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_done", 32'(bus.done), 32'd0);
    for (int i = 0; i < DEPTH; i++) host_wr(i, DW'($urandom));
    copy(8'h05, 8'h00, 30, 1'b0, 1'b0, 8'h00);
    scan("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
